// File: rtl/onchip_memory_arbiter.sv
// onchip_memory_arbiter
//
// Shares one single-port on-chip RAM (Avalon-MM s1 slave) between two
// Avalon-MM masters: port A (video DMA) and port B (CPU data master).
// At most one access reaches the RAM per cycle. When both ports request
// in the same cycle, the port favoured by a round-robin priority flop wins.
// Read data is routed back to the issuing master after a fixed latency.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   a_* / b_*         Avalon-MM slave ports for master A / master B
//                     (address, byteenable, read, write, writedata in;
//                      waitrequest, readdata, readdatavalid out)
//   mem_*             Avalon-MM master side towards the RAM s1 port
//                     (address, byteenable, chipselect, write, writedata,
//                      clken out; readdata in)
//
// Parameters
//   ADDR_WIDTH        word address width of the RAM and of both ports
//   DATA_WIDTH        data width
//   BE_WIDTH          byteenable width (DATA_WIDTH/8)
//   READ_LATENCY      cycles from an accepted read to valid mem_readdata (1..4)

module onchip_memory_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BE_WIDTH     = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [BE_WIDTH-1:0]   a_byteenable,
  input  logic                  a_read,
  input  logic                  a_write,
  input  logic [DATA_WIDTH-1:0] a_writedata,
  output logic                  a_waitrequest,
  output logic [DATA_WIDTH-1:0] a_readdata,
  output logic                  a_readdatavalid,

  input  logic [ADDR_WIDTH-1:0] b_address,
  input  logic [BE_WIDTH-1:0]   b_byteenable,
  input  logic                  b_read,
  input  logic                  b_write,
  input  logic [DATA_WIDTH-1:0] b_writedata,
  output logic                  b_waitrequest,
  output logic [DATA_WIDTH-1:0] b_readdata,
  output logic                  b_readdatavalid,

  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_WIDTH-1:0] mem_readdata
);

  // Which port wins a simultaneous request.
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  // Owner tag carried alongside each in-flight read.
  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  prio_t  prio;

  logic   req_a;
  logic   req_b;
  logic   grant_a;
  logic   grant_b;
  logic   read_accept;
  owner_t read_owner;

  // Read return pipeline: one {valid, owner} entry per latency stage.
  logic   rd_valid [READ_LATENCY];
  owner_t rd_owner [READ_LATENCY];

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;

  // Grant selection. Gated off during reset so that nothing is accepted
  // and the RAM is never written while reset is asserted.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (req_a && req_b) begin
        if (prio == PRIO_A) grant_a = 1'b1;
        else                grant_b = 1'b1;
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  assign a_waitrequest = req_a & ~grant_a;
  assign b_waitrequest = req_b & ~grant_b;

  // Read together with write counts as a write: no read is tracked for it.
  always_comb begin
    read_accept = 1'b0;
    read_owner  = OWNER_A;
    if (grant_a) begin
      read_accept = a_read & ~a_write;
      read_owner  = OWNER_A;
    end else if (grant_b) begin
      read_accept = b_read & ~b_write;
      read_owner  = OWNER_B;
    end
  end

  // Round-robin: the port just served loses priority to the other one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= PRIO_A;
    end else if (grant_a) begin
      prio <= PRIO_B;
    end else if (grant_b) begin
      prio <= PRIO_A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        rd_valid[i] <= 1'b0;
        rd_owner[i] <= OWNER_A;
      end
    end else begin
      rd_valid[0] <= read_accept;
      rd_owner[0] <= read_owner;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        rd_valid[i] <= rd_valid[i-1];
        rd_owner[i] <= rd_owner[i-1];
      end
    end
  end

  // RAM drive: muxed from whichever port is granted this cycle.
  always_comb begin
    mem_address    = a_address;
    mem_byteenable = a_byteenable;
    mem_writedata  = a_writedata;
    mem_write      = 1'b0;
    if (grant_b) begin
      mem_address    = b_address;
      mem_byteenable = b_byteenable;
      mem_writedata  = b_writedata;
      mem_write      = b_write;
    end else if (grant_a) begin
      mem_write      = a_write;
    end
  end

  assign mem_chipselect = grant_a | grant_b;
  assign mem_clken      = 1'b1;

  // Return path: both ports see the RAM data, only the owner gets valid.
  assign a_readdata      = mem_readdata;
  assign b_readdata      = mem_readdata;
  assign a_readdatavalid = rd_valid[READ_LATENCY-1] & (rd_owner[READ_LATENCY-1] == OWNER_A);
  assign b_readdatavalid = rd_valid[READ_LATENCY-1] & (rd_owner[READ_LATENCY-1] == OWNER_B);

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
module tb_onchip_memory_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 1: READ_LATENCY = 1 ----------------
  logic [11:0] a_address, b_address, mem_address;
  logic [3:0]  a_byteenable, b_byteenable, mem_byteenable;
  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_writedata, b_writedata, mem_writedata;
  logic        a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
  logic [31:0] a_readdata, b_readdata, mem_readdata;
  logic        mem_chipselect, mem_write, mem_clken;

  onchip_memory_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BE_WIDTH(4), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read), .b_write(b_write),
    .b_writedata(b_writedata), .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h010) return 32'hDEADBEEF;
    if (i == 5)       return 32'hAAAAAAAA;
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // RAM model: registered address, unregistered output.
  logic [31:0] ram [4096];
  logic [11:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int j = 0; j < 4; j++)
          if (mem_byteenable[j]) ram[mem_address][j*8 +: 8] <= mem_writedata[j*8 +: 8];
      end
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  // ---------------- DUT 2: READ_LATENCY = 2 ----------------
  logic [11:0] l2_a_address, l2_mem_address;
  logic        l2_a_read, l2_a_waitrequest, l2_a_readdatavalid;
  logic [31:0] l2_a_readdata, l2_b_readdata, l2_mem_writedata, l2_mem_readdata;
  logic        l2_b_waitrequest, l2_b_readdatavalid;
  logic [3:0]  l2_mem_byteenable;
  logic        l2_mem_chipselect, l2_mem_write, l2_mem_clken;

  onchip_memory_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BE_WIDTH(4), .READ_LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset),
    .a_address(l2_a_address), .a_byteenable(4'hF), .a_read(l2_a_read), .a_write(1'b0),
    .a_writedata(32'h0), .a_waitrequest(l2_a_waitrequest), .a_readdata(l2_a_readdata),
    .a_readdatavalid(l2_a_readdatavalid),
    .b_address(12'h0), .b_byteenable(4'h0), .b_read(1'b0), .b_write(1'b0),
    .b_writedata(32'h0), .b_waitrequest(l2_b_waitrequest), .b_readdata(l2_b_readdata),
    .b_readdatavalid(l2_b_readdatavalid),
    .mem_address(l2_mem_address), .mem_byteenable(l2_mem_byteenable),
    .mem_chipselect(l2_mem_chipselect), .mem_write(l2_mem_write),
    .mem_writedata(l2_mem_writedata), .mem_clken(l2_mem_clken), .mem_readdata(l2_mem_readdata)
  );

  // Read-only RAM model with an extra output register (two-cycle latency).
  logic [31:0] ram2 [4096];
  logic [11:0] ram2_addr_q = '0;
  logic [31:0] ram2_q = '0;
  always @(posedge clk) begin
    if (l2_mem_chipselect) ram2_addr_q <= l2_mem_address;
    ram2_q <= ram2[ram2_addr_q];
  end
  assign l2_mem_readdata = ram2_q;

  // ---------------- Scoreboard ----------------
  typedef struct {
    bit          port;   // 0 = A, 1 = B
    logic [31:0] data;
    int          at_cyc;
  } sb_t;
  sb_t sb_q[$];

  logic [31:0] shadow [4096];

  always @(negedge clk) begin
    sb_t e;
    logic [31:0] got;
    if (a_readdatavalid || b_readdatavalid) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rdv cyc=%0d a_rdv=%b b_rdv=%b required none", cyc, a_readdatavalid, b_readdatavalid);
      end else begin
        e = sb_q.pop_front();
        got = e.port ? b_readdata : a_readdata;
        if ({a_readdatavalid, b_readdatavalid} !== (e.port ? 2'b01 : 2'b10) ||
            cyc !== e.at_cyc || got !== e.data) begin
          bad++;
          $display("FAIL read_return cyc=%0d rdv_ab=%b data=%h required cyc=%0d port=%s data=%h",
                   cyc, {a_readdatavalid, b_readdatavalid}, got, e.at_cyc, e.port ? "B" : "A", e.data);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].at_cyc <= cyc) begin
      e = sb_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_rdv cyc=%0d got no readdatavalid required port=%s at cyc=%0d",
               cyc, e.port ? "B" : "A", e.at_cyc);
    end
  end

  // One bus cycle: present requests, sample acceptance mid-cycle, record
  // the expected outcome of accepted accesses. Called at posedge+1.
  task automatic drive_cycle(
    input logic ar, input logic aw, input logic [11:0] aa, input logic [3:0] abe, input logic [31:0] awd,
    input logic br, input logic bw, input logic [11:0] ba, input logic [3:0] bbe, input logic [31:0] bwd,
    output logic acc_a, output logic acc_b);
    sb_t e;
    a_read = ar; a_write = aw; a_address = aa; a_byteenable = abe; a_writedata = awd;
    b_read = br; b_write = bw; b_address = ba; b_byteenable = bbe; b_writedata = bwd;
    @(negedge clk);
    acc_a = (ar | aw) & ~a_waitrequest;
    acc_b = (br | bw) & ~b_waitrequest;
    if (acc_a) begin
      if (aw) begin
        for (int j = 0; j < 4; j++) if (abe[j]) shadow[aa][j*8 +: 8] = awd[j*8 +: 8];
      end else begin
        e.port = 1'b0; e.data = shadow[aa]; e.at_cyc = cyc + 1; sb_q.push_back(e);
      end
    end
    if (acc_b) begin
      if (bw) begin
        for (int j = 0; j < 4; j++) if (bbe[j]) shadow[ba][j*8 +: 8] = bwd[j*8 +: 8];
      end else begin
        e.port = 1'b1; e.data = shadow[ba]; e.at_cyc = cyc + 1; sb_q.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    logic x, y;
    for (int i = 0; i < n; i++) drive_cycle(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, x, y);
  endtask

  task automatic pulse_reset();
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (a_readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_a_rdv got=%b required=0", a_readdatavalid); end
    total++; if (b_readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_b_rdv got=%b required=0", b_readdatavalid); end
    total++; if (mem_clken !== 1'b1) begin bad++; $display("FAIL rst_clken got=%b required=1", mem_clken); end
    total++; if (a_waitrequest !== 1'b0 || b_waitrequest !== 1'b0) begin
      bad++; $display("FAIL rst_idle_wait got=%b%b required=00", a_waitrequest, b_waitrequest); end
    // Requests during reset must not reach the RAM.
    a_read = 1; a_address = 12'h010; b_write = 1; b_address = 12'h011; b_byteenable = 4'hF; b_writedata = 32'h1;
    @(negedge clk);
    total++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin
      bad++; $display("FAIL rst_no_access cs=%b wr=%b required cs=0 wr=0", mem_chipselect, mem_write); end
    a_read = 0; b_write = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (a_waitrequest !== 1'b0 || a_readdatavalid !== 1'b0) begin
      bad++; $display("FAIL post_rst_idle wait=%b rdv=%b required 0 0", a_waitrequest, a_readdatavalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    logic x, y;
    drive_cycle(1, 0, 12'h010, 4'hF, '0, 0, 0, '0, '0, '0, x, y);
    total++; if (x !== 1'b1) begin bad++; $display("FAIL single_read_accept got=%b required=1", x); end
    idle(2);
  endtask

  task automatic test_contention();
    logic x, y;
    int ia = 0, ib = 0, n = 0, n_acc = 0;
    int order [8];
    pulse_reset();
    while ((ia < 4 || ib < 4) && n < 20) begin
      drive_cycle(0, ia < 4, 12'(12'h100 + ia), 4'hF, 32'hA0000000 + 32'(ia),
                  0, ib < 4, 12'(12'h200 + ib), 4'hF, 32'hB0000000 + 32'(ib), x, y);
      if (x && y) begin total++; bad++; $display("FAIL double_grant cyc=%0d both accepted required one", cyc); end
      if (x) begin if (n_acc < 8) order[n_acc] = 0; n_acc++; ia++; end
      if (y) begin if (n_acc < 8) order[n_acc] = 1; n_acc++; ib++; end
      n++;
    end
    total++; if (n !== 8 || n_acc !== 8) begin
      bad++; $display("FAIL contention_cycles got cycles=%0d accepts=%0d required 8 8", n, n_acc); end
    for (int k = 0; k < 8 && k < n_acc; k++) begin
      total++; if (order[k] !== (k % 2)) begin
        bad++; $display("FAIL grant_order[%0d] got=%s required=%s", k, order[k] ? "B" : "A", (k % 2) ? "B" : "A"); end
    end
    // Read all eight words back through port A.
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1, 0, (k < 4) ? 12'(12'h100 + k) : 12'(12'h200 + k - 4), 4'hF, '0,
                  0, 0, '0, '0, '0, x, y);
      total++; if (x !== 1'b1) begin bad++; $display("FAIL readback_accept[%0d] got=%b required=1", k, x); end
    end
    idle(2);
  endtask

  task automatic test_byteenable();
    logic x, y;
    drive_cycle(0, 0, '0, '0, '0, 0, 1, 12'h005, 4'h3, 32'h12345678, x, y);
    total++; if (y !== 1'b1) begin bad++; $display("FAIL be_write_accept got=%b required=1", y); end
    drive_cycle(1, 0, 12'h005, 4'hF, '0, 0, 0, '0, '0, '0, x, y);
    total++; if (shadow[5] !== 32'hAAAA5678) begin
      bad++; $display("FAIL be_model got=%h required=aaaa5678", shadow[5]); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic x, y;
    drive_cycle(1, 0, 12'h001, 4'hF, '0, 0, 0, '0, '0, '0, x, y);
    total++; if (x !== 1'b1) begin bad++; $display("FAIL b2b_a1 got=%b required=1", x); end
    drive_cycle(0, 0, '0, '0, '0, 1, 0, 12'h002, 4'hF, '0, x, y);
    total++; if (y !== 1'b1) begin bad++; $display("FAIL b2b_b2 got=%b required=1", y); end
    drive_cycle(1, 0, 12'h003, 4'hF, '0, 0, 0, '0, '0, '0, x, y);
    total++; if (x !== 1'b1) begin bad++; $display("FAIL b2b_a3 got=%b required=1", x); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    logic x, y;
    drive_cycle(1, 0, 12'h010, 4'hF, '0, 0, 0, '0, '0, '0, x, y);
    if (x) void'(sb_q.pop_back());   // reset discards this in-flight read
    reset = 1'b1;
    #1;
    total++; if (a_readdatavalid !== 1'b0) begin
      bad++; $display("FAIL mid_rst_rdv got=%b required=0", a_readdatavalid); end
    @(negedge clk);
    total++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin
      bad++; $display("FAIL mid_rst_cs cs=%b wr=%b required 0 0", mem_chipselect, mem_write); end
    @(posedge clk); #1;
    a_read = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    drive_cycle(1, 0, 12'h020, 4'hF, '0, 1, 0, 12'h021, 4'hF, '0, x, y);
    total++; if (x !== 1'b1 || y !== 1'b0) begin
      bad++; $display("FAIL post_rst_prio got acc_a=%b acc_b=%b required 1 0", x, y); end
    drive_cycle(0, 0, '0, '0, '0, 1, 0, 12'h021, 4'hF, '0, x, y);
    idle(2);
  endtask

  task automatic test_latency2();
    l2_a_address = 12'h007;
    l2_a_read = 1'b1;
    @(negedge clk);
    total++; if (l2_a_waitrequest !== 1'b0) begin
      bad++; $display("FAIL l2_accept wait=%b required=0", l2_a_waitrequest); end
    @(posedge clk); #1;
    l2_a_read = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++; if (l2_a_readdatavalid !== (k == 2) || l2_b_readdatavalid !== 1'b0) begin
        bad++; $display("FAIL l2_rdv[%0d] a=%b b=%b required a=%b b=0", k, l2_a_readdatavalid,
                        l2_b_readdatavalid, k == 2); end
      if (k == 2) begin
        total++; if (l2_a_readdata !== init_word(7)) begin
          bad++; $display("FAIL l2_data got=%h required=%h", l2_a_readdata, init_word(7)); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = init_word(i);
      ram2[i] = init_word(i);
      shadow[i] = init_word(i);
    end
    reset = 1'b1;
    a_read = 0; a_write = 0; a_address = '0; a_byteenable = '0; a_writedata = '0;
    b_read = 0; b_write = 0; b_address = '0; b_byteenable = '0; b_writedata = '0;
    l2_a_read = 0; l2_a_address = '0;

    test_reset();
    test_single_read();
    test_contention();
    test_byteenable();
    test_back_to_back();
    test_reset_mid();
    test_latency2();
    idle(3);

    total++; if (sb_q.size() !== 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d pending required=0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
